mem_port_arbiter: RTL and testbench

//  Shares one unified single-ported memory between IF-stage fetch and MEM-stage load/store.

---
 rtl/mem_port_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// mem_port_if: bundles the fetch, data and memory-macro signals shared by the
// pipeline stages, the memory macro and mem_port_arbiter.
//   slave  modport: the arbiter's view (requests and mem_rdata in; grants,
//                   read data, memory strobes and stalls out).
//   master modport: the opposite side (pipeline stages plus memory macro).
interface mem_port_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [31:0]       if_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;

    // Memory macro side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Hazard-unit stalls
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, d_gnt, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, d_gnt, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF-stage fetch and
// MEM-stage load/store. One access in flight at a time, each lasting MEM_LAT
// cycles, completed by a one-cycle grant pulse to its owner. Data wins ties
// unless fetch has already lost STARVE_MAX consecutive contended rounds.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active low
//   bus  - mem_port_if.slave: if_*/d_* request ports, mem_* macro port,
//          stall_if/stall_mem (combinational) to the hazard logic
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_port_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1) < 1 ? 1 : $clog2(STARVE_MAX + 1);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ST_W-1:0]   starve_q,    starve_d;
    logic              op_we_q,     op_we_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q,    if_gnt_d;
    logic              d_gnt_q,     d_gnt_d;
    logic [31:0]       if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    // A requester in its grant cycle may still hold req; ignore it so the
    // finished access is not issued a second time.
    logic if_act, d_act;
    assign if_act = bus.if_req & ~if_gnt_q;
    assign d_act  = bus.d_req  & ~d_gnt_q;

    // Arbitration, issue and completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        op_we_d     = op_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (d_act && (!if_act || (starve_q < ST_W'(STARVE_MAX)))) begin
                    state_d     = ST_BUSY_D;
                    cnt_d       = CNT_W'(MEM_LAT);
                    op_we_d     = bus.d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    // Only a contended loss counts against fetch
                    if (if_act) begin
                        starve_d = starve_q + ST_W'(1);
                    end
                end else if (if_act) begin
                    state_d     = ST_BUSY_I;
                    cnt_d       = CNT_W'(MEM_LAT);
                    op_we_d     = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_BUSY_I) begin
                        if_gnt_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata[31:0];
                    end else begin
                        d_gnt_d = 1'b1;
                        if (!op_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            op_we_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            op_we_q     <= op_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_gnt_q;
    assign bus.stall_mem = bus.d_req  & ~d_gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory macro stand-in: a fresh read word per access, held until the next
    logic [63:0] rd_val    = 64'h0;
    logic [63:0] fixed_rd  = 64'h0;
    bit          use_fixed = 1'b0;
    assign bus.mem_rdata = rd_val;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each access is a record with a completion edge.
    longint      edge_n     = 0;
    longint      done_edge  = 0;
    bit          pend       = 1'b0;
    bit          p_if       = 1'b0;
    bit          p_we       = 1'b0;
    int          starve     = 0;
    bit          model_ok   = 1'b0;
    logic        exp_mem_en = 1'b0, exp_mem_we = 1'b0;
    logic        exp_if_gnt = 1'b0, exp_d_gnt  = 1'b0;
    logic [63:0] exp_mem_addr = 64'h0, exp_mem_wdata = 64'h0, exp_d_rdata = 64'h0;
    logic [31:0] exp_if_rdata = 32'h0;

    always @(posedge clk) begin
        bit prev_ig, prev_dg, mi, md;
        edge_n++;
        if (!rst) begin
            pend = 1'b0; starve = 0;
            exp_mem_en = 1'b0; exp_mem_we = 1'b0; exp_if_gnt = 1'b0; exp_d_gnt = 1'b0;
            exp_mem_addr = '0; exp_mem_wdata = '0; exp_d_rdata = '0; exp_if_rdata = '0;
        end else begin
            prev_ig = exp_if_gnt;
            prev_dg = exp_d_gnt;
            exp_if_gnt = 1'b0; exp_d_gnt = 1'b0; exp_mem_en = 1'b0; exp_mem_we = 1'b0;
            if (pend) begin
                if (edge_n == done_edge) begin
                    pend = 1'b0;
                    if (p_if) begin
                        exp_if_gnt   = 1'b1;
                        exp_if_rdata = rd_val[31:0];
                    end else begin
                        exp_d_gnt = 1'b1;
                        if (!p_we) exp_d_rdata = rd_val;
                    end
                end
            end else begin
                mi = bus.if_req && !prev_ig;
                md = bus.d_req && !prev_dg;
                if (md && (!mi || starve < int'(STARVE_MAX))) begin
                    if (mi) starve++;
                    pend = 1'b1; p_if = 1'b0; p_we = bus.d_we;
                    done_edge     = edge_n + longint'(MEM_LAT);
                    exp_mem_en    = 1'b1;
                    exp_mem_we    = bus.d_we;
                    exp_mem_addr  = bus.d_addr;
                    exp_mem_wdata = bus.d_wdata;
                end else if (mi) begin
                    starve = 0;
                    pend = 1'b1; p_if = 1'b1; p_we = 1'b0;
                    done_edge     = edge_n + longint'(MEM_LAT);
                    exp_mem_en    = 1'b1;
                    exp_mem_we    = 1'b0;
                    exp_mem_addr  = bus.if_addr;
                    exp_mem_wdata = '0;
                end
            end
        end
        model_ok = 1'b1;
    end

    // Per-cycle comparison on the falling edge, then advance the memory word
    always @(negedge clk) begin
        if (model_ok) begin
            chk1 ("mem_en",    bus.mem_en,    exp_mem_en);
            chk1 ("mem_we",    bus.mem_we,    exp_mem_we);
            chk64("mem_addr",  bus.mem_addr,  exp_mem_addr);
            chk64("mem_wdata", bus.mem_wdata, exp_mem_wdata);
            chk1 ("if_gnt",    bus.if_gnt,    exp_if_gnt);
            chk1 ("d_gnt",     bus.d_gnt,     exp_d_gnt);
            chk64("if_rdata",  64'(bus.if_rdata), 64'(exp_if_rdata));
            chk64("d_rdata",   bus.d_rdata,   exp_d_rdata);
            chk1 ("stall_if",  bus.stall_if,  bus.if_req & ~exp_if_gnt);
            chk1 ("stall_mem", bus.stall_mem, bus.d_req & ~exp_d_gnt);
            chk1 ("gnt_excl",  bus.if_gnt & bus.d_gnt, 1'b0);
        end
        if (bus.mem_en === 1'b1) begin
            rd_val = use_fixed ? fixed_rd : {$urandom(), $urandom()};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  dg;
        bit  fetched;
        bit  done;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset held two cycles with both requests high
        bus.if_req = 1'b1; bus.if_addr = 64'h600;
        bus.d_req  = 1'b1; bus.d_addr  = 64'h500;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1 ("rst_mem_en",   bus.mem_en, 1'b0);
            chk1 ("rst_if_gnt",   bus.if_gnt, 1'b0);
            chk1 ("rst_d_gnt",    bus.d_gnt,  1'b0);
            chk64("rst_mem_addr", bus.mem_addr, 64'h0);
            chk64("rst_d_rdata",  bus.d_rdata,  64'h0);
            chk64("rst_if_rdata", 64'(bus.if_rdata), 64'h0);
        end
        rst = 1'b1;
        step();
        chk1 ("rel_mem_en",   bus.mem_en, 1'b1);
        chk64("rel_mem_addr", bus.mem_addr, 64'h500);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        step(); step();
        chk1("dropped_req_still_gnt", bus.d_gnt, 1'b1);
        repeat (3) step();

        // Single fetch, fixed instruction word
        use_fixed = 1'b1; fixed_rd = 64'h0000_0000_D503_201F;
        bus.if_req = 1'b1; bus.if_addr = 64'h40;
        step();
        chk1 ("f_mem_en",   bus.mem_en, 1'b1);
        chk64("f_mem_addr", bus.mem_addr, 64'h40);
        chk1 ("f_stall1",   bus.stall_if, 1'b1);
        step();
        chk1 ("f_mem_en_1cyc", bus.mem_en, 1'b0);
        chk1 ("f_stall2",      bus.stall_if, 1'b1);
        step();
        chk1 ("f_if_gnt",   bus.if_gnt, 1'b1);
        chk64("f_if_rdata", 64'(bus.if_rdata), 64'hD503_201F);
        chk1 ("f_stall_gnt", bus.stall_if, 1'b0);
        bus.if_req = 1'b0;
        step();
        chk1("f_gnt_pulse", bus.if_gnt, 1'b0);
        step();

        // Simultaneous requests: data first, fetch issues at the d_gnt edge
        use_fixed = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 64'h200;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h80;
        step();
        chk64("both_data_first", bus.mem_addr, 64'h80);
        step(); step();
        chk1("both_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 1'b0;
        step();
        chk1 ("both_if_issue",  bus.mem_en, 1'b1);
        chk64("both_if_addr",   bus.mem_addr, 64'h200);
        step(); step();
        chk1("both_if_gnt", bus.if_gnt, 1'b1);
        bus.if_req = 1'b0;
        repeat (2) step();

        // Starvation limit: fetch re-contends after each data grant
        use_fixed = 1'b1; fixed_rd = 64'h1234_5678_9ABC_DEF0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h300;
        bus.if_req = 1'b1; bus.if_addr = 64'h700;
        dg = 0; fetched = 1'b0;
        for (int c = 0; c < 100 && !fetched; c++) begin
            step();
            if (bus.d_gnt) begin
                dg++;
                bus.if_req = 1'b0;
            end else if (bus.if_gnt) begin
                fetched = 1'b1;
            end else begin
                bus.if_req = 1'b1;
            end
        end
        chk1 ("starve_fetch_won", fetched, 1'b1);
        chk64("starve_d_gnts", 64'(dg), 64'd4);
        bus.if_req = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (bus.d_gnt) done = 1'b1;
        end
        chk1("starve_d_after", done, 1'b1);
        bus.d_req = 1'b0;
        step();

        // Store leaves d_rdata unchanged
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h100; bus.d_wdata = 64'hDEAD_BEEF;
        step();
        chk1 ("st_mem_en",    bus.mem_en, 1'b1);
        chk1 ("st_mem_we",    bus.mem_we, 1'b1);
        chk64("st_mem_addr",  bus.mem_addr, 64'h100);
        chk64("st_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
        step();
        chk1("st_we_1cyc", bus.mem_we, 1'b0);
        step();
        chk1 ("st_d_gnt",   bus.d_gnt, 1'b1);
        chk64("st_d_rdata", bus.d_rdata, 64'h1234_5678_9ABC_DEF0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();

        // Reset during the second BUSY cycle abandons the load
        use_fixed = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 64'h180;
        step();
        chk1("rb_issue", bus.mem_en, 1'b1);
        step();
        rst = 1'b0;
        step();
        chk1 ("rb_no_gnt",  bus.d_gnt, 1'b0);
        chk1 ("rb_mem_en",  bus.mem_en, 1'b0);
        chk64("rb_d_rdata", bus.d_rdata, 64'h0);
        rst = 1'b1;
        step();
        chk1 ("rb_reissue",      bus.mem_en, 1'b1);
        chk64("rb_reissue_addr", bus.mem_addr, 64'h180);
        step();
        chk1("rb_not_early", bus.d_gnt, 1'b0);
        step();
        chk1("rb_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 1'b0;
        step();

        // Randomized traffic with occasional fetch flushes and resets
        for (int c = 0; c < 3000; c++) begin
            step();
            if (bus.if_gnt) begin
                bus.if_req  = 1'($urandom_range(1, 0));
                bus.if_addr = {$urandom(), $urandom()};
            end else if (!bus.if_req) begin
                if ($urandom_range(2, 0) == 0) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = {$urandom(), $urandom()};
                end
            end else if ($urandom_range(15, 0) == 0) begin
                bus.if_req = 1'b0;
            end
            if (bus.d_gnt || !bus.d_req) begin
                bus.d_req   = ($urandom_range(1, 0) == 0);
                bus.d_we    = 1'($urandom_range(1, 0));
                bus.d_addr  = {$urandom(), $urandom()};
                bus.d_wdata = {$urandom(), $urandom()};
            end
            rst = ($urandom_range(199, 0) != 0);
        end

        bus.if_req = 1'b0; bus.d_req = 1'b0; rst = 1'b1;
        repeat (8) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
